// File: rtl/rggen_irq_coalescer_if.sv
// Signal bundle between the RC status fields / CSR block and the interrupt coalescer.
interface rggen_irq_coalescer_if #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = 8
);
    logic [WIDTH-1:0]       i_status;
    logic [WIDTH-1:0]       i_enable;
    logic [COUNT_WIDTH-1:0] i_threshold;
    logic [COUNT_WIDTH-1:0] i_timeout;
    logic                   o_irq;
    logic [COUNT_WIDTH-1:0] o_event_count;
    logic                   o_busy;

    modport master (
        output i_status, i_enable, i_threshold, i_timeout,
        input  o_irq, o_event_count, o_busy
    );

    modport slave (
        input  i_status, i_enable, i_threshold, i_timeout,
        output o_irq, o_event_count, o_busy
    );
endinterface

// File: rtl/rggen_irq_coalescer.sv
// Interrupt moderation: counts rising enabled status bits and raises an irq on
// an event-count threshold or holdoff timeout, held until the status is cleared.
module rggen_irq_coalescer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned PULSE_MODE  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    rggen_irq_coalescer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ASSERT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] timer_q, timer_d;
    logic [WIDTH-1:0]       status_q, status_d;
    logic                   irq_q, irq_d;
    logic                   busy_q, busy_d;

    logic [WIDTH-1:0]       masked;
    logic                   active;
    logic                   new_event;
    logic [COUNT_WIDTH-1:0] eff_threshold;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] timer_next;

    always_comb begin
        masked        = bus.i_status & bus.i_enable;
        active        = |masked;
        new_event     = |(masked & ~status_q);
        eff_threshold = (bus.i_threshold == '0) ? ONE : bus.i_threshold;
        timer_next    = (timer_q == '1) ? timer_q : timer_q + ONE;
        count_next    = (count_q == '1 || !new_event) ? count_q : count_q + ONE;

        status_d = masked;
        state_d  = state_q;
        count_d  = count_q;
        timer_d  = timer_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                timer_d = '0;
                if (new_event) begin
                    count_d = ONE;
                    state_d = (eff_threshold == ONE) ? ST_ASSERT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!active) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    timer_d = '0;
                end else begin
                    count_d = count_next;
                    timer_d = timer_next;
                    if (count_next >= eff_threshold ||
                        (bus.i_timeout != '0 && timer_next >= bus.i_timeout)) begin
                        state_d = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (!active) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase

        // Pulse mode also fires on fresh events during ASSERT so partial clears lose nothing.
        if (PULSE_MODE != 0) begin
            irq_d = (state_d == ST_ASSERT) &&
                    ((state_q != ST_ASSERT) || new_event);
        end else begin
            irq_d = (state_d == ST_ASSERT);
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            timer_q  <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            status_q <= status_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_irq         = irq_q;
    assign bus.o_event_count = count_q;
    assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Directed bench for rggen_irq_coalescer: a level-mode and a pulse-mode
// instance driven by identical inputs, checked against hand-computed values.
module tb_rggen_irq_coalescer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rggen_irq_coalescer_if #(.WIDTH(8), .COUNT_WIDTH(8)) bus_l ();
    rggen_irq_coalescer_if #(.WIDTH(8), .COUNT_WIDTH(8)) bus_p ();

    assign bus_p.i_status    = bus_l.i_status;
    assign bus_p.i_enable    = bus_l.i_enable;
    assign bus_p.i_threshold = bus_l.i_threshold;
    assign bus_p.i_timeout   = bus_l.i_timeout;

    rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(8), .PULSE_MODE(0)) u_level (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_l.slave)
    );

    rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(8), .PULSE_MODE(1)) u_pulse (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_p.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_l(input string tag, input logic irq, input logic [7:0] cnt, input logic busy);
        check({tag, ".irq"},   {31'd0, bus_l.o_irq}, {31'd0, irq});
        check({tag, ".count"}, {24'd0, bus_l.o_event_count}, {24'd0, cnt});
        check({tag, ".busy"},  {31'd0, bus_l.o_busy}, {31'd0, busy});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_l.i_status    = 8'h00;
        bus_l.i_enable    = 8'hFF;
        bus_l.i_threshold = 8'd3;
        bus_l.i_timeout   = 8'd0;
        #12;
        chk_l("reset", 1'b0, 8'd0, 1'b0);
        check("reset.pulse_irq", {31'd0, bus_p.o_irq}, 32'd0);
        rst_n = 1'b1;
        step();

        // Threshold trigger
        bus_l.i_status = 8'h01; step(); chk_l("thr.e1", 1'b0, 8'd1, 1'b1);
        bus_l.i_status = 8'h03; step(); chk_l("thr.e2", 1'b0, 8'd2, 1'b1);
        bus_l.i_status = 8'h07; step(); chk_l("thr.e3", 1'b1, 8'd3, 1'b1);
        step();                         chk_l("thr.hold", 1'b1, 8'd3, 1'b1);
        bus_l.i_status = 8'h00; step(); chk_l("thr.clear", 1'b0, 8'd0, 1'b0);

        // Timeout trigger: WAIT entered at edge E
        bus_l.i_threshold = 8'd4;
        bus_l.i_timeout   = 8'd10;
        bus_l.i_status    = 8'h01;
        step(); chk_l("to.E", 1'b0, 8'd1, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("to.E+%0d.irq", i), {31'd0, bus_l.o_irq}, 32'd0);
        end
        step(); chk_l("to.E+10", 1'b1, 8'd1, 1'b1);
        bus_l.i_status = 8'h00; step(); chk_l("to.clear", 1'b0, 8'd0, 1'b0);

        // Immediate mode
        bus_l.i_threshold = 8'd0;
        bus_l.i_timeout   = 8'd0;
        bus_l.i_status    = 8'h20;
        step(); chk_l("imm", 1'b1, 8'd1, 1'b1);
        bus_l.i_status = 8'h00; step(); chk_l("imm.clear", 1'b0, 8'd0, 1'b0);

        // Masking
        bus_l.i_threshold = 8'd3;
        bus_l.i_enable    = 8'h0F;
        bus_l.i_status    = 8'h80;
        step(); chk_l("mask.off", 1'b0, 8'd0, 1'b0);
        step(); chk_l("mask.off2", 1'b0, 8'd0, 1'b0);
        bus_l.i_enable = 8'hFF;
        step(); chk_l("mask.on", 1'b0, 8'd1, 1'b1);
        bus_l.i_enable = 8'h0F;
        step(); chk_l("mask.disable", 1'b0, 8'd0, 1'b0);
        bus_l.i_status = 8'h00;
        bus_l.i_enable = 8'hFF;
        step();

        // Pulse mode, threshold 1
        bus_l.i_threshold = 8'd1;
        bus_l.i_status    = 8'h01;
        step(); check("pulse.p1", {31'd0, bus_p.o_irq}, 32'd1);
                check("pulse.p1.busy", {31'd0, bus_p.o_busy}, 32'd1);
        step(); check("pulse.p1.end", {31'd0, bus_p.o_irq}, 32'd0);
                check("pulse.level_held", {31'd0, bus_l.o_irq}, 32'd1);
        bus_l.i_status = 8'h03;
        step(); check("pulse.p2", {31'd0, bus_p.o_irq}, 32'd1);
        step(); check("pulse.p2.end", {31'd0, bus_p.o_irq}, 32'd0);
                check("pulse.p2.busy", {31'd0, bus_p.o_busy}, 32'd1);
        bus_l.i_status = 8'h00;
        step(); check("pulse.clear", {31'd0, bus_p.o_irq}, 32'd0);
                check("pulse.clear.busy", {31'd0, bus_p.o_busy}, 32'd0);
        step(); check("pulse.idle", {31'd0, bus_p.o_irq}, 32'd0);

        // Abort mid-WAIT
        bus_l.i_threshold = 8'd5;
        bus_l.i_timeout   = 8'd20;
        bus_l.i_status    = 8'h01;
        step(); chk_l("abort.wait", 1'b0, 8'd1, 1'b1);
        step(); chk_l("abort.wait2", 1'b0, 8'd1, 1'b1);
        bus_l.i_status = 8'h00;
        step(); chk_l("abort.idle", 1'b0, 8'd0, 1'b0);

        // Asynchronous reset while in ASSERT
        bus_l.i_threshold = 8'd1;
        bus_l.i_timeout   = 8'd0;
        bus_l.i_status    = 8'h01;
        step(); chk_l("rst.pre", 1'b1, 8'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_l("rst.async", 1'b0, 8'd0, 1'b0);
        check("rst.async.pulse_busy", {31'd0, bus_p.o_busy}, 32'd0);
        #2 rst_n = 1'b1;
        step(); chk_l("rst.reentry", 1'b1, 8'd1, 1'b1);
        check("rst.reentry.pulse", {31'd0, bus_p.o_irq}, 32'd1);
        bus_l.i_status = 8'h00;
        step(); chk_l("rst.clear", 1'b0, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rggen_irq_coalescer.md
# rggen_irq_coalescer

Interrupt moderation stage that sits directly downstream of a group of read-clear status bit fields. It consumes their `o_value` vector, qualifies it with a per-bit enable, and counts newly raised events. It asserts the interrupt request once an event-count threshold or a holdoff timeout is reached. The request is held or pulsed until software clears the status by reading the RC fields.

## Interface
Parameters:
- `WIDTH`, default 8: number of status bits consumed.
- `COUNT_WIDTH`, default 8: width of the event counter, holdoff timer, threshold and timeout.
- `PULSE_MODE`, default 0: 0 = level interrupt; 1 = one-cycle pulse per assertion.

Ports:
- `i_clk`, input, 1: the block's single clock.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_status`, input, `WIDTH`: status vector, driven from RC field `o_value`.
- `i_enable`, input, `WIDTH`: per-bit interrupt enable.
- `i_threshold`, input, `COUNT_WIDTH`: event count that triggers assertion. A value of 0 is treated as 1.
- `i_timeout`, input, `COUNT_WIDTH`: holdoff limit in cycles. A value of 0 disables the timer.
- `o_irq`, output, 1: interrupt request.
- `o_event_count`, output, `COUNT_WIDTH`: events counted in the current coalescing window.
- `o_busy`, output, 1: high whenever the state is not IDLE.

## Operation
Signal definitions:
- `masked = i_status & i_enable`.
- `active = |masked`.
- `status_q` is the registered copy of `masked`, reset value 0.
- `new_event = |(masked & ~status_q)`, a combinational 0→1 transition on any enabled bit. One `new_event` cycle counts as 1 event, regardless of how many bits rose.

State machine (IDLE, WAIT, ASSERT), reset state IDLE:
- **IDLE.** Count = 0, timer = 0.
  - On `new_event` with effective threshold = 1: go to ASSERT.
  - On `new_event` otherwise: go to WAIT with count = 1, timer = 0.
- **WAIT.** Each cycle:
  - `timer_next = timer + 1`.
  - `count_next = count + new_event`.
  - Both saturate at 2^`COUNT_WIDTH` − 1.
  - Transitions, in priority order:
    1. `active == 0`: go to IDLE. The count and timer clear.
    2. `count_next >= threshold`, or (`i_timeout != 0` and `timer_next >= i_timeout`): go to ASSERT.
    3. Otherwise: stay in WAIT.
  - Threshold and timeout are compared live each cycle, not latched.
- **ASSERT.** The count is frozen. Go to IDLE when `active == 0`.

Output behaviour:
- **Level mode:** `o_irq` = 1 exactly while the state is ASSERT.
- **Pulse mode:** `o_irq` = 1 for one cycle on entry to ASSERT. It also pulses for one cycle on any `new_event` while already in ASSERT, so partial clears do not lose events.
- `o_event_count` shows the registered count. It reads 1 in ASSERT when entered directly from IDLE.
- Clearing enables has the same effect as clearing status: `active` drops and the block returns to IDLE.

## Timing
- All outputs are registered.
- Reset values: `o_irq` = 0, `o_event_count` = 0, `o_busy` = 0, `status_q` = 0, state = IDLE.
- Latency: if an enabled bit rises in the cycle before edge E and the threshold is ≤ 1, then `o_irq` = 1 after edge E (1 cycle).
- Timeout path: if WAIT is entered at edge E, then `o_irq` rises at edge E + `i_timeout`, provided the threshold is not reached earlier.
- Release: `active` falls before edge F, so `o_irq` (level mode) and `o_busy` are 0 after edge F.
- Clear-and-new-event can never coincide in one cycle, because `new_event` implies `active`.
- A status bit that stays high does not re-trigger. It must fall and rise again to count.
- A reset asserted mid-WAIT or mid-ASSERT drops all outputs immediately, without waiting for a clock edge. After reset release, bits that are already set count as new events, because `status_q` = 0.

## Test plan
- **Threshold trigger.** Setup: threshold 3, timeout 0, enable all. Stimulus: bits 0, 1 and 2 rise on separate cycles. Required response:
  - `o_event_count` steps 1, 2.
  - `o_irq` rises one edge after the third rise, with the count showing 3.
  - Clear the status: `o_irq` is 0 and `o_busy` is 0 one edge later.
- **Timeout trigger.** Setup: threshold 4, timeout 10. Stimulus: a single event, with WAIT entered at edge E. Required response: `o_irq` = 0 through E+9 and 1 at E+10, with `o_event_count` = 1.
- **Immediate mode.** Setup: threshold 0. Stimulus: bit 5 rises. Required response: `o_irq` = 1 after the next edge; `o_busy` = 1.
- **Masking.** Setup: `i_enable` = 8'h0F. Stimulus: bit 7 rises. Required response: no state change and `o_irq` stays 0. Then enable bit 7 while it is high: counts as 1 event.
- **Pulse mode.** Setup: `PULSE_MODE` = 1, threshold 1. Stimulus and required response:
  - Bit 0 rises: one 1-cycle pulse.
  - Bit 1 rises while in ASSERT: a second 1-cycle pulse.
  - Clear all: back to IDLE with no pulse.
- **Abort and reset.** Required response:
  - Status cleared mid-WAIT (threshold 5, timeout 20): return to IDLE with count 0 and no `o_irq`.
  - `i_rst_n` asserted in ASSERT: all outputs 0 without a clock edge.
  - After release with status still high: new WAIT or ASSERT entry at the first edge.
